uart_tx_core: RTL and testbench
===============================

Name: uart_tx_core

Overview:
Transmit half of the UART core. It buffers bytes written by the host in an internal FIFO and serialises each byte onto the tx wire. Each frame is a start bit, 8 data bits (LSB or MSB first), an optional parity bit, and one stop bit. Bit timing comes from the shared baudrate generator's BaudSig_i pulse. It sits in UartCore beside the receive core and shares the same control register fields (parity enable, parity method, big-end).

Parameters:
DEPTH, 16, FIFO depth in bytes; power of 2, minimum 2.
PTR_W, 4, FIFO pointer width = log2(DEPTH).

Ports:
clk  in  1  system clock; single clock domain.
rst  in  1  reset; asynchronous, active-high.
data_i  in  8  byte to queue.
n_we_i  in  1  FIFO write strobe, active low, 1 clk wide per byte.
n_clr_i  in  1  FIFO clear, active low.
p_full_o  out  1  FIFO full.
p_empty_o  out  1  FIFO empty.
BaudSig_i  in  1  1-clk pulse per bit period, from the baudrate generator.
p_ParityEnable_i  in  1  1 = send parity bit.
p_BigEnd_i  in  1  1 = bit7 sent first; 0 = bit0 sent first.
ParityMethod_i  in  1  0 = even, 1 = odd.
Tx_o  out  1  tx wire, registered; idles high.
p_busy_o  out  1  high whenever state != IDLE.
TxByteNum_o  out  8  count of completed frames; wraps modulo 256.

Behaviour:
- Reset values: Tx_o=1, state=IDLE, FIFO empty, p_empty_o=1, p_full_o=0, p_busy_o=0, TxByteNum_o=0. Reset mid-frame aborts the frame immediately; Tx_o returns to 1.
- FIFO write: accepted when n_we_i=0 and p_full_o=0. A write while full is dropped; no flag is raised.
- FIFO clear: n_clr_i=0 empties the FIFO in the same cycle and wins over a simultaneous write or pop. It does not abort the frame in flight.
- Simultaneous write and pop in one cycle: both are performed. A write at full is rejected even if a pop occurs in that cycle.
- FSM: all state transitions happen only in cycles where BaudSig_i=1. Tx_o updates on the clock edge that ends the BaudSig_i cycle, i.e. 1 clk latency.
  - IDLE: Tx_o=1. On BaudSig_i with FIFO non-empty: pop the byte into the shift register, latch p_BigEnd_i, p_ParityEnable_i and ParityMethod_i, compute parity, set Tx_o=0, go to START. Config changes mid-frame have no effect.
  - START: on BaudSig_i, drive the first data bit, set bit counter to 1, go to DATA.
  - DATA: on BaudSig_i with counter<8, drive the next bit and increment the counter. With counter=8, drive the parity bit and go to PARITY if parity is enabled; otherwise drive 1 and go to STOP.
  - PARITY: on BaudSig_i, drive 1, go to STOP.
  - STOP: on BaudSig_i, increment TxByteNum_o. If the FIFO is non-empty, pop the next byte, drive 0 and go to START (back-to-back frames, no idle bit). Otherwise go to IDLE.
- Parity bit: even method = XOR of the 8 data bits; odd method = XNOR of the 8 data bits.
- Frame length: 10 bit periods without parity, 11 with parity.
- The first start bit can begin up to one bit period after the write, because the pop waits for the next BaudSig_i.

Optional Feature:
UART_TX_INTERVAL_EN
- With the macro defined: adds input IntervalBits_i[3:0] and state INTERVAL. After STOP, Tx_o is held at 1 for IntervalBits_i further bit periods before the next start bit. IntervalBits_i=0 behaves as back-to-back. The value is latched on entry to INTERVAL. With an empty FIFO at the end of INTERVAL the FSM goes to IDLE.
- Without the macro: no port and no state; STOP goes directly to START or IDLE as above.

Decomposition:
- Shared package uart_pkg holds:
  - the 5-bit one-hot state encoding (IDLE, START, DATA, PARITY, STOP), same width as the receive FSM state bus; INTERVAL reuses IDLE's encoding qualified by a flag;
  - the PARITY_EVEN/PARITY_ODD constants;
  - the DATA_BITS=8 constant.
- Sub-module uart_tx_fifo (parameterised by DEPTH, PTR_W) holds the storage, pointers, full/empty logic and clear. The FSM, shift register and parity logic stay in uart_tx_core.

Test Plan:
1. Write 0xA5, parity off, little-end, BaudSig_i every 16 clk -> Tx_o sequence 0,1,0,1,0,0,1,0,1,1; TxByteNum_o=1; p_busy_o drops; Tx_o stays 1.
2. 0x03, parity on, even then odd, big-end -> data bits 0,0,0,0,0,0,1,1; parity bit 0 (even) then 1 (odd); 11-bit frame.
3. Write 3 bytes 0x11,0x22,0x33 back-to-back -> three contiguous frames with no idle bit between them; TxByteNum_o=3; p_empty_o=1 after the third pop.
4. Write DEPTH+2 bytes with BaudSig_i held low -> p_full_o=1 after DEPTH writes; last 2 bytes dropped; only DEPTH frames sent once BaudSig_i runs.
5. Assert n_clr_i during DATA of frame 1 with 4 bytes queued -> frame 1 completes; no further frames; p_empty_o=1.
6. Assert rst in DATA of a frame -> Tx_o=1, TxByteNum_o=0, p_busy_o=0 immediately. With UART_TX_INTERVAL_EN and IntervalBits_i=2 -> 2 extra high bit periods between frames.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: one-hot FSM state encoding, parity methods, frame data width.
package uart_pkg;

  typedef enum logic [4:0] {
    ST_IDLE   = 5'b00001,
    ST_START  = 5'b00010,
    ST_DATA   = 5'b00100,
    ST_PARITY = 5'b01000,
    ST_STOP   = 5'b10000
  } uart_state_e;

  localparam logic PARITY_EVEN = 1'b0;
  localparam logic PARITY_ODD  = 1'b1;

  localparam int unsigned DATA_BITS = 8;

  function automatic logic parity_of(input logic [DATA_BITS-1:0] data, input logic method);
    logic p;
    p = ^data;
    case (method)
      PARITY_EVEN: parity_of = p;
      PARITY_ODD:  parity_of = ~p;
      default:     parity_of = p;
    endcase
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Transmit byte FIFO: circular buffer with occupancy count; clear wins over write and pop.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned PTR_W = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] i_data,
  input  logic                 i_wr,
  input  logic                 i_rd,
  input  logic                 i_clr,
  output logic [DATA_BITS-1:0] o_data,
  output logic                 o_full,
  output logic                 o_empty
);

  logic [DATA_BITS-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]     r_wr_ptr;
  logic [PTR_W-1:0]     r_rd_ptr;
  logic [PTR_W:0]       r_count;
  logic                 w_wr_ok;
  logic                 w_rd_ok;

  assign o_full  = (r_count == (PTR_W+1)'(DEPTH));
  assign o_empty = (r_count == '0);
  assign w_wr_ok = i_wr && !o_full && !i_clr;
  assign w_rd_ok = i_rd && !o_empty && !i_clr;
  assign o_data  = r_mem[r_rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_clr) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd_ok) r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_wr_ok && !w_rd_ok)      r_count <= r_count + 1'b1;
      else if (!w_wr_ok && w_rd_ok) r_count <= r_count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr_ok) r_mem[r_wr_ptr] <= i_data;
  end

endmodule

// File: rtl/uart_tx_core.sv
// UART transmitter: FIFO-buffered bytes serialised as start/data/[parity]/stop frames.
// Optional inter-frame gap enabled by defining UART_TX_INTERVAL_EN.
module uart_tx_core
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned PTR_W = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data_i,
  input  logic       n_we_i,
  input  logic       n_clr_i,
  output logic       p_full_o,
  output logic       p_empty_o,
  input  logic       BaudSig_i,
  input  logic       p_ParityEnable_i,
  input  logic       p_BigEnd_i,
  input  logic       ParityMethod_i,
`ifdef UART_TX_INTERVAL_EN
  input  logic [3:0] IntervalBits_i,
`endif
  output logic       Tx_o,
  output logic       p_busy_o,
  output logic [7:0] TxByteNum_o
);

  localparam logic [3:0] LAST_BIT = 4'(DATA_BITS);

  uart_state_e          r_state, w_state_nxt;
  logic [DATA_BITS-1:0] r_shift, w_shift_nxt;
  logic                 r_big, w_big_nxt;
  logic                 r_par_en, w_par_en_nxt;
  logic                 r_par_bit, w_par_bit_nxt;
  logic [3:0]           r_bit_cnt, w_bit_cnt_nxt;
  logic                 r_tx, w_tx_nxt;
  logic [7:0]           r_byte_num, w_byte_num_nxt;
  logic [DATA_BITS-1:0] w_fifo_data;
  logic                 w_full, w_empty;
  logic                 w_pop, w_load, w_avail;
  logic                 w_cur_bit;
  logic [DATA_BITS-1:0] w_shifted;
`ifdef UART_TX_INTERVAL_EN
  logic                 r_in_ivl, w_in_ivl_nxt;
  logic [3:0]           r_ivl_cnt, w_ivl_cnt_nxt;
`endif

  uart_tx_fifo #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_data  (data_i),
    .i_wr    (!n_we_i),
    .i_rd    (w_pop),
    .i_clr   (!n_clr_i),
    .o_data  (w_fifo_data),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // A clear in the same cycle as a pop opportunity must not start a frame from stale data.
  assign w_avail   = !w_empty && n_clr_i;
  assign w_cur_bit = r_big ? r_shift[DATA_BITS-1] : r_shift[0];
  assign w_shifted = r_big ? {r_shift[DATA_BITS-2:0], 1'b0} : {1'b0, r_shift[DATA_BITS-1:1]};

  always_comb begin
    w_state_nxt    = r_state;
    w_shift_nxt    = r_shift;
    w_big_nxt      = r_big;
    w_par_en_nxt   = r_par_en;
    w_par_bit_nxt  = r_par_bit;
    w_bit_cnt_nxt  = r_bit_cnt;
    w_tx_nxt       = r_tx;
    w_byte_num_nxt = r_byte_num;
    w_load         = 1'b0;
    w_pop          = 1'b0;
`ifdef UART_TX_INTERVAL_EN
    w_in_ivl_nxt   = r_in_ivl;
    w_ivl_cnt_nxt  = r_ivl_cnt;
`endif
    if (BaudSig_i) begin
      unique case (r_state)
        ST_IDLE: begin
`ifdef UART_TX_INTERVAL_EN
          // INTERVAL shares IDLE's encoding; r_in_ivl marks the inter-frame gap.
          if (r_in_ivl) begin
            if (r_ivl_cnt > 4'd1) begin
              w_ivl_cnt_nxt = r_ivl_cnt - 4'd1;
            end else begin
              w_in_ivl_nxt = 1'b0;
              if (w_avail) w_load = 1'b1;
            end
          end else
`endif
          if (w_avail) w_load = 1'b1;
        end
        ST_START: begin
          w_tx_nxt      = w_cur_bit;
          w_shift_nxt   = w_shifted;
          w_bit_cnt_nxt = 4'd1;
          w_state_nxt   = ST_DATA;
        end
        ST_DATA: begin
          if (r_bit_cnt < LAST_BIT) begin
            w_tx_nxt      = w_cur_bit;
            w_shift_nxt   = w_shifted;
            w_bit_cnt_nxt = r_bit_cnt + 4'd1;
          end else if (r_par_en) begin
            w_tx_nxt    = r_par_bit;
            w_state_nxt = ST_PARITY;
          end else begin
            w_tx_nxt    = 1'b1;
            w_state_nxt = ST_STOP;
          end
        end
        ST_PARITY: begin
          w_tx_nxt    = 1'b1;
          w_state_nxt = ST_STOP;
        end
        ST_STOP: begin
          w_byte_num_nxt = r_byte_num + 8'd1;
`ifdef UART_TX_INTERVAL_EN
          if (IntervalBits_i != '0) begin
            w_in_ivl_nxt  = 1'b1;
            w_ivl_cnt_nxt = IntervalBits_i;
            w_state_nxt   = ST_IDLE;
          end else
`endif
          if (w_avail) w_load = 1'b1;
          else         w_state_nxt = ST_IDLE;
        end
        default: begin
          w_tx_nxt    = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      endcase
    end
    if (w_load) begin
      w_pop         = 1'b1;
      w_shift_nxt   = w_fifo_data;
      w_big_nxt     = p_BigEnd_i;
      w_par_en_nxt  = p_ParityEnable_i;
      w_par_bit_nxt = parity_of(w_fifo_data, ParityMethod_i);
      w_tx_nxt      = 1'b0;
      w_state_nxt   = ST_START;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_shift    <= '0;
      r_big      <= 1'b0;
      r_par_en   <= 1'b0;
      r_par_bit  <= 1'b0;
      r_bit_cnt  <= '0;
      r_tx       <= 1'b1;
      r_byte_num <= '0;
`ifdef UART_TX_INTERVAL_EN
      r_in_ivl   <= 1'b0;
      r_ivl_cnt  <= '0;
`endif
    end else begin
      r_state    <= w_state_nxt;
      r_shift    <= w_shift_nxt;
      r_big      <= w_big_nxt;
      r_par_en   <= w_par_en_nxt;
      r_par_bit  <= w_par_bit_nxt;
      r_bit_cnt  <= w_bit_cnt_nxt;
      r_tx       <= w_tx_nxt;
      r_byte_num <= w_byte_num_nxt;
`ifdef UART_TX_INTERVAL_EN
      r_in_ivl   <= w_in_ivl_nxt;
      r_ivl_cnt  <= w_ivl_cnt_nxt;
`endif
    end
  end

  assign Tx_o        = r_tx;
  assign TxByteNum_o = r_byte_num;
  assign p_full_o    = w_full;
  assign p_empty_o   = w_empty;
`ifdef UART_TX_INTERVAL_EN
  assign p_busy_o    = (r_state != ST_IDLE) || r_in_ivl;
`else
  assign p_busy_o    = (r_state != ST_IDLE);
`endif

endmodule

// File: tb/tb_uart_tx_core.sv
// Bench for uart_tx_core: frame-level reference model checked every cycle, plus literal frame checks.
module tb_uart_tx_core;

  localparam int DEPTH = 16;
`ifdef UART_TX_INTERVAL_EN
  localparam int IVL = 2;
`else
  localparam int IVL = 0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] data_i;
  logic       n_we_i, n_clr_i;
  logic       p_full_o, p_empty_o;
  logic       BaudSig_i;
  logic       p_ParityEnable_i, p_BigEnd_i, ParityMethod_i;
  logic       Tx_o, p_busy_o;
  logic [7:0] TxByteNum_o;

  always #5 clk = ~clk;

  uart_tx_core #(.DEPTH(DEPTH), .PTR_W(4)) dut (
    .clk              (clk),
    .rst              (rst),
    .data_i           (data_i),
    .n_we_i           (n_we_i),
    .n_clr_i          (n_clr_i),
    .p_full_o         (p_full_o),
    .p_empty_o        (p_empty_o),
    .BaudSig_i        (BaudSig_i),
    .p_ParityEnable_i (p_ParityEnable_i),
    .p_BigEnd_i       (p_BigEnd_i),
    .ParityMethod_i   (ParityMethod_i),
`ifdef UART_TX_INTERVAL_EN
    .IntervalBits_i   (4'(IVL)),
`endif
    .Tx_o             (Tx_o),
    .p_busy_o         (p_busy_o),
    .TxByteNum_o      (TxByteNum_o)
  );

  int unsigned total = 0;
  int unsigned bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: byte queue plus a queue of line bits per frame, advanced once per bit period.
  logic [7:0] fifo_q[$];
  bit         line_q[$];
  bit         rec_q[$];
  bit         m_active, m_tx, rec_pending;
  logic [7:0] m_cnt;
  int         gap;

  task automatic m_reset();
    fifo_q.delete();
    line_q.delete();
    m_active    = 1'b0;
    m_tx        = 1'b1;
    m_cnt       = 8'd0;
    gap         = 0;
    rec_pending = 1'b0;
  endtask

  task automatic m_step();
    int pre;
    logic [7:0] b;
    pre = fifo_q.size();
    if (BaudSig_i) begin
      rec_pending = 1'b1;
      if (m_active && line_q.size() == 0) begin
        m_cnt    = m_cnt + 8'd1;
        m_active = 1'b0;
        gap      = IVL;
      end else if (gap > 0) begin
        gap--;
      end
      if (!m_active && gap == 0 && pre > 0 && n_clr_i) begin
        b = fifo_q.pop_front();
        line_q.push_back(1'b0);
        for (int i = 0; i < 8; i++) line_q.push_back(p_BigEnd_i ? b[7-i] : b[i]);
        if (p_ParityEnable_i) line_q.push_back((^b) ^ ParityMethod_i);
        line_q.push_back(1'b1);
        m_active = 1'b1;
      end
      m_tx = m_active ? line_q.pop_front() : 1'b1;
    end
    if (!n_clr_i) fifo_q.delete();
    else if (!n_we_i && pre < DEPTH) fifo_q.push_back(data_i);
  endtask

  initial begin
    m_reset();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) m_reset();
      else     m_step();
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (rec_pending) begin
        rec_q.push_back(Tx_o);
        rec_pending = 1'b0;
      end
      chk("tx",    Tx_o,        m_tx);
      chk("busy",  p_busy_o,    m_active || gap > 0);
      chk("count", TxByteNum_o, m_cnt);
      chk("full",  p_full_o,    fifo_q.size() == DEPTH);
      chk("empty", p_empty_o,   fifo_q.size() == 0);
    end
  end

  bit baud_run = 1'b0;
  int bdiv = 0;
  initial begin
    BaudSig_i = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (baud_run && bdiv == 15) begin
        BaudSig_i = 1'b1;
        bdiv = 0;
      end else begin
        BaudSig_i = 1'b0;
        if (baud_run) bdiv++;
      end
    end
  end

  task automatic write_byte(input logic [7:0] b);
    @(posedge clk); #1;
    data_i = b;
    n_we_i = 1'b0;
    @(posedge clk); #1;
    n_we_i = 1'b1;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    rec_q.delete();
  endtask

  task automatic wait_idle(input int max_cycles);
    int n;
    n = 0;
    while (!(p_busy_o == 1'b0 && p_empty_o == 1'b1) && n < max_cycles) begin
      @(negedge clk);
      n++;
    end
    if (n >= max_cycles) begin
      total++;
      bad++;
      $display("FAIL wait_idle: busy=%0b empty=%0b after %0d cycles", p_busy_o, p_empty_o, n);
    end
    repeat (40) @(posedge clk);
  endtask

  task automatic wait_busy(input int max_cycles);
    int n;
    n = 0;
    while (p_busy_o !== 1'b1 && n < max_cycles) begin
      @(negedge clk);
      n++;
    end
    if (n >= max_cycles) begin
      total++;
      bad++;
      $display("FAIL wait_busy: busy=%0b after %0d cycles", p_busy_o, n);
    end
  endtask

  function automatic int find0(input int from);
    for (int i = from; i < rec_q.size(); i++) if (rec_q[i] == 1'b0) return i;
    return rec_q.size();
  endfunction

  task automatic get_frame(input int s, input int n, output logic [31:0] v);
    v = '0;
    for (int i = 0; i < n; i++)
      v = {v[30:0], (s + i < rec_q.size()) ? rec_q[s+i] : 1'b1};
  endtask

  logic [31:0] fr;
  int          s, s2;

  initial begin
    rst = 1'b1;
    data_i = 8'h00;
    n_we_i = 1'b1;
    n_clr_i = 1'b1;
    p_ParityEnable_i = 1'b0;
    p_BigEnd_i = 1'b0;
    ParityMethod_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tx", Tx_o, 1'b1);
    chk("rst_busy", p_busy_o, 1'b0);
    chk("rst_count", TxByteNum_o, 8'd0);
    chk("rst_empty", p_empty_o, 1'b1);
    chk("rst_full", p_full_o, 1'b0);
    rst = 1'b0;
    baud_run = 1'b1;

    // 0xA5, no parity, LSB first
    do_reset();
    write_byte(8'hA5);
    wait_idle(600);
    s = find0(0);
    get_frame(s, 10, fr);
    chk("t1_frame", fr, 32'b0101001011);
    chk("t1_count", TxByteNum_o, 8'd1);
    chk("t1_busy", p_busy_o, 1'b0);
    chk("t1_idle_tx", Tx_o, 1'b1);

    // 0x03, parity on, MSB first, even then odd
    do_reset();
    p_ParityEnable_i = 1'b1;
    p_BigEnd_i = 1'b1;
    ParityMethod_i = 1'b0;
    write_byte(8'h03);
    wait_idle(600);
    ParityMethod_i = 1'b1;
    write_byte(8'h03);
    wait_idle(600);
    s = find0(0);
    get_frame(s, 11, fr);
    chk("t2_even", fr, 32'b00000001101);
    s2 = find0(s + 11);
    get_frame(s2, 11, fr);
    chk("t2_odd", fr, 32'b00000001111);
    chk("t2_count", TxByteNum_o, 8'd2);

    // Three queued bytes go out as contiguous frames
    do_reset();
    p_ParityEnable_i = 1'b0;
    p_BigEnd_i = 1'b0;
    ParityMethod_i = 1'b0;
    write_byte(8'h11);
    write_byte(8'h22);
    write_byte(8'h33);
    wait_idle(1200);
    s = find0(0);
    get_frame(s, 10, fr);
    chk("t3_frame1", fr, 32'b0100010001);
    chk("t3_start2", rec_q[s + 10 + IVL], 1'b0);
    chk("t3_stop1", rec_q[s + 9], 1'b1);
    get_frame(s + 2 * (10 + IVL), 10, fr);
    chk("t3_frame3", fr, 32'b0110011001);
    chk("t3_count", TxByteNum_o, 8'd3);
    chk("t3_empty", p_empty_o, 1'b1);

    // Overfill with baud stopped: last two writes dropped
    do_reset();
    baud_run = 1'b0;
    for (int i = 0; i < DEPTH; i++) write_byte(8'h40 + 8'(i));
    chk("t4_full", p_full_o, 1'b1);
    write_byte(8'hEE);
    write_byte(8'hEF);
    chk("t4_still_full", p_full_o, 1'b1);
    baud_run = 1'b1;
    wait_idle(DEPTH * 16 * 14 + 400);
    chk("t4_count", TxByteNum_o, 8'(DEPTH));
    chk("t4_empty", p_empty_o, 1'b1);

    // Clear during first frame's data bits
    do_reset();
    write_byte(8'h5A);
    write_byte(8'h6B);
    write_byte(8'h7C);
    write_byte(8'h8D);
    wait_busy(100);
    repeat (3 * 16 + 4) @(posedge clk);
    #1;
    n_clr_i = 1'b0;
    @(posedge clk); #1;
    n_clr_i = 1'b1;
    chk("t5_empty_now", p_empty_o, 1'b1);
    chk("t5_busy_now", p_busy_o, 1'b1);
    wait_idle(600);
    chk("t5_count", TxByteNum_o, 8'd1);
    chk("t5_empty", p_empty_o, 1'b1);

    // Reset mid-frame
    do_reset();
    write_byte(8'h77);
    wait_idle(600);
    chk("t6_pre_count", TxByteNum_o, 8'd1);
    write_byte(8'h88);
    wait_busy(100);
    repeat (40) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("t6_tx", Tx_o, 1'b1);
    chk("t6_count", TxByteNum_o, 8'd0);
    chk("t6_busy", p_busy_o, 1'b0);
    chk("t6_empty", p_empty_o, 1'b1);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (40) @(posedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
